// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage core: load-use, branch flush, multi-cycle EX, memory wait.
// Optional perf counters (stall_cycles, flush_events) are built only when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl #(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_multicycle,
  input  logic        ex_branch_taken,
  input  logic        mem_wait,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        exmem_stall,
  output logic        exmem_bubble,
  output logic        mc_busy,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  localparam logic ST_RUN     = 1'b0;
  localparam logic ST_MC_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 1);

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;

  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    exmem_bubble = 1'b0;
    if (rst) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (mem_wait) begin
      // Full freeze: FSM and counter hold so the multi-cycle sequence is only extended.
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
    end else if (state_q == ST_RUN) begin
      if (ex_multicycle) begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_bubble = 1'b1;
        state_d      = ST_MC_BUSY;
        cnt_d        = CNT_LOAD;
      end else if (ex_branch_taken) begin
        // ID holds a wrong-path instruction, so a coincident load-use is irrelevant.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end else if (cnt_q > CNT_ONE) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      exmem_bubble = 1'b1;
      cnt_d        = cnt_q - CNT_ONE;
    end else begin
      // Release cycle: the op leaves EX; branch and load-use inputs are ignored.
      state_d = ST_RUN;
      cnt_d   = '0;
    end
  end

  assign mc_busy = !rst && (state_q == ST_MC_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (ifid_flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = rst ? 32'd0 : stall_cnt_q;
  assign flush_events = rst ? 32'd0 : flush_cnt_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule
